// File: rtl/pllmap_spi_rx.sv
// SPI slave receive/decode stage: oversamples sclk/mosi/ss_n, deserializes one
// frame per ss_n window, updates PLL config on good write frames, returns status on miso.
module pllmap_spi_rx #(
  parameter int unsigned DATA_WIDTH = 512,
  parameter logic [9:0]  RATIO_RST  = 10'd6
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sclk,
  input  logic       mosi,
  input  logic       ss_n,
  input  logic       lock,
  output logic       miso,
  output logic [9:0] cfg_ratio,
  output logic       cfg_pllen,
  output logic       cfg_valid,
  output logic       rx_finish,
  output logic       frame_err
);

  localparam int unsigned CNT_W   = $clog2(DATA_WIDTH) + 1;
  localparam int unsigned RATIO_W = 10;
  localparam int unsigned STAT_W  = RATIO_W + 2;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_e;

  state_e                state_q, state_d;
  logic [2:0]            sclk_pipe_q, sclk_pipe_d;
  logic [2:0]            ss_pipe_q, ss_pipe_d;
  logic [1:0]            mosi_pipe_q, mosi_pipe_d;
  logic [DATA_WIDTH-1:0] frame_q, frame_d;
  logic [DATA_WIDTH-1:0] shadow_q, shadow_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  miso_q, miso_d;
  logic [RATIO_W-1:0]    cfg_ratio_q, cfg_ratio_d;
  logic                  cfg_pllen_q, cfg_pllen_d;
  logic                  cfg_valid_q, cfg_valid_d;
  logic                  rx_finish_q, rx_finish_d;
  logic                  frame_err_q, frame_err_d;

  logic sclk_rise_c, sclk_fall_c, ss_rise_c, ss_low_c, mosi_sync_c;
  logic frame_unused_c;

  // Events from the synchronized stage [1] against the edge-detect stage [2]
  assign sclk_rise_c = sclk_pipe_q[1] & ~sclk_pipe_q[2];
  assign sclk_fall_c = ~sclk_pipe_q[1] & sclk_pipe_q[2];
  assign ss_rise_c   = ss_pipe_q[1] & ~ss_pipe_q[2];
  // Level test so a select that falls during DONE is still picked up in IDLE
  assign ss_low_c    = ~ss_pipe_q[1];
  assign mosi_sync_c = mosi_pipe_q[1];

  assign frame_unused_c = frame_q[DATA_WIDTH-1] ^ shadow_q[DATA_WIDTH-1];

  always_comb begin
    state_d     = state_q;
    sclk_pipe_d = {sclk_pipe_q[1:0], sclk};
    ss_pipe_d   = {ss_pipe_q[1:0], ss_n};
    mosi_pipe_d = {mosi_pipe_q[0], mosi};
    frame_d     = frame_q;
    shadow_d    = shadow_q;
    cnt_d       = cnt_q;
    miso_d      = miso_q;
    cfg_ratio_d = cfg_ratio_q;
    cfg_pllen_d = cfg_pllen_q;
    cfg_valid_d = 1'b0;
    rx_finish_d = 1'b0;
    frame_err_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (ss_low_c) begin
          state_d                  = SHIFT;
          cnt_d                    = '0;
          shadow_d                 = '0;
          shadow_d[STAT_W-1:0]     = {lock, cfg_pllen_q, cfg_ratio_q};
          miso_d                   = shadow_d[DATA_WIDTH-1];
        end
      end
      SHIFT: begin
        if (sclk_rise_c) begin
          frame_d = {frame_q[DATA_WIDTH-2:0], mosi_sync_c};
          if (cnt_q != CNT_W'(DATA_WIDTH)) begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        if (sclk_fall_c) begin
          shadow_d = {shadow_q[DATA_WIDTH-2:0], 1'b0};
          miso_d   = shadow_q[DATA_WIDTH-2];
        end
        if (ss_rise_c) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
        if (cnt_q == CNT_W'(DATA_WIDTH)) begin
          rx_finish_d = 1'b1;
          if (frame_q[1]) begin
            cfg_pllen_d = frame_q[2];
            cfg_ratio_d = frame_q[12:3];
            cfg_valid_d = 1'b1;
          end
        end else begin
          frame_err_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Synchronizers reset to the idle bus levels so reset release creates no events
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      sclk_pipe_q <= 3'b000;
      ss_pipe_q   <= 3'b111;
      mosi_pipe_q <= 2'b00;
      frame_q     <= '0;
      shadow_q    <= '0;
      cnt_q       <= '0;
      miso_q      <= 1'b0;
      cfg_ratio_q <= RATIO_RST;
      cfg_pllen_q <= 1'b0;
      cfg_valid_q <= 1'b0;
      rx_finish_q <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      sclk_pipe_q <= sclk_pipe_d;
      ss_pipe_q   <= ss_pipe_d;
      mosi_pipe_q <= mosi_pipe_d;
      frame_q     <= frame_d;
      shadow_q    <= shadow_d;
      cnt_q       <= cnt_d;
      miso_q      <= miso_d;
      cfg_ratio_q <= cfg_ratio_d;
      cfg_pllen_q <= cfg_pllen_d;
      cfg_valid_q <= cfg_valid_d;
      rx_finish_q <= rx_finish_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign miso      = miso_q;
  assign cfg_ratio = cfg_ratio_q;
  assign cfg_pllen = cfg_pllen_q;
  assign cfg_valid = cfg_valid_q;
  assign rx_finish = rx_finish_q;
  assign frame_err = frame_err_q;

endmodule

// File: tb/tb_pllmap_spi_rx.sv
// Bench for pllmap_spi_rx: drives SPI frames as a mode-0 master and checks outputs
// every cycle against a frame-level model of the decode rules.
module tb_pllmap_spi_rx;

  localparam int unsigned DW = 512;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       sclk = 1'b0;
  logic       mosi = 1'b0;
  logic       ss_n = 1'b1;
  logic       lock = 1'b0;
  logic       miso;
  logic [9:0] cfg_ratio;
  logic       cfg_pllen;
  logic       cfg_valid;
  logic       rx_finish;
  logic       frame_err;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Frame results scheduled by the driver, consumed by the compare process
  int         sched_id = 0;
  int         sched_cyc = 0;
  int         rise_cyc = 0;
  logic       sched_good = 1'b0;
  logic       sched_wr = 1'b0;
  logic       sched_pllen = 1'b0;
  logic [9:0] sched_ratio = '0;

  // Model state, owned by the compare process
  int         done_id = 0;
  logic [9:0] m_ratio = 10'd6;
  logic       m_pllen = 1'b0;
  int         n_valid = 0;
  int         n_fin = 0;
  int         n_err = 0;
  int         last_fin_cyc = -1;
  int         last_valid_cyc = -1;

  logic tx_bits[$];
  logic cap[$];

  pllmap_spi_rx #(.DATA_WIDTH(DW), .RATIO_RST(10'd6)) dut (
    .clk(clk), .rst_n(rst_n), .sclk(sclk), .mosi(mosi), .ss_n(ss_n), .lock(lock),
    .miso(miso), .cfg_ratio(cfg_ratio), .cfg_pllen(cfg_pllen),
    .cfg_valid(cfg_valid), .rx_finish(rx_finish), .frame_err(frame_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    logic e_valid, e_fin, e_err;
    if (cyc >= 2) begin
      e_valid = 1'b0;
      e_fin   = 1'b0;
      e_err   = 1'b0;
      if (!rst_n) begin
        m_ratio = 10'd6;
        m_pllen = 1'b0;
        done_id = sched_id;
      end else if (done_id != sched_id && cyc == sched_cyc) begin
        done_id = sched_id;
        if (sched_good) begin
          e_fin = 1'b1;
          if (sched_wr) begin
            e_valid = 1'b1;
            m_ratio = sched_ratio;
            m_pllen = sched_pllen;
          end
        end else begin
          e_err = 1'b1;
        end
      end
      check("cfg_ratio", int'(cfg_ratio), int'(m_ratio));
      check("cfg_pllen", int'(cfg_pllen), int'(m_pllen));
      check("cfg_valid", int'(cfg_valid), int'(e_valid));
      check("rx_finish", int'(rx_finish), int'(e_fin));
      check("frame_err", int'(frame_err), int'(e_err));
      if (!rst_n) check("miso_in_reset", int'(miso), 0);
      if (cfg_valid) begin n_valid++; last_valid_cyc = cyc; end
      if (rx_finish) begin n_fin++; last_fin_cyc = cyc; end
      if (frame_err) n_err++;
    end
  end

  task automatic load(input logic [DW-1:0] w, input int nbits, input int extra);
    tx_bits.delete();
    for (int k = 0; k < extra; k++) tx_bits.push_back(1'b1);
    for (int k = nbits - 1; k >= 0; k--) tx_bits.push_back(w[k]);
  endtask

  // Mode-0 master: 5-cycle half period; abort_at>0 pulls reset after that many bits
  task automatic send_frame(input int abort_at);
    int n;
    logic [DW-1:0] w;
    @(posedge clk); #1 ss_n = 1'b0;
    cap.delete();
    repeat (5) @(posedge clk); #1;
    for (int i = 0; i < tx_bits.size(); i++) begin
      if (abort_at > 0 && i == abort_at) begin
        rst_n = 1'b0; ss_n = 1'b1; sclk = 1'b0; mosi = 1'b0;
        repeat (3) @(posedge clk); #1 rst_n = 1'b1;
        repeat (10) @(posedge clk); #1;
        return;
      end
      mosi = tx_bits[i];
      repeat (5) @(posedge clk); #1;
      cap.push_back(miso);
      sclk = 1'b1;
      repeat (5) @(posedge clk); #1 sclk = 1'b0;
    end
    repeat (5) @(posedge clk); #1 ss_n = 1'b1;
    n = tx_bits.size();
    for (int j = 0; j < DW; j++) w[j] = (j < n) ? tx_bits[n-1-j] : 1'b0;
    sched_good  = (n >= DW);
    sched_wr    = w[1];
    sched_pllen = w[2];
    sched_ratio = w[12:3];
    sched_cyc   = cyc + 4;
    rise_cyc    = cyc;
    sched_id++;
    repeat (10) @(posedge clk); #1;
  endtask

  initial begin
    logic [DW-1:0] w;
    logic [11:0]   tail;
    logic [11:0]   exp_tail;
    int            ones;
    int            v0, f0, e0;

    repeat (5) @(posedge clk); #1 rst_n = 1'b1;
    repeat (3) @(posedge clk); #1;
    check("rst_ratio", int'(cfg_ratio), 6);
    check("rst_pllen", int'(cfg_pllen), 0);
    check("rst_miso", int'(miso), 0);
    check("rst_pulses", int'(cfg_valid) + int'(rx_finish) + int'(frame_err), 0);

    // Write frame: pllen=1, ratio=11
    w = '0; w[1] = 1'b1; w[2] = 1'b1; w[12:3] = 10'd11;
    v0 = n_valid; f0 = n_fin; e0 = n_err;
    load(w, DW, 0);
    send_frame(0);
    check("wr_valid_cnt", n_valid - v0, 1);
    check("wr_fin_cnt", n_fin - f0, 1);
    check("wr_err_cnt", n_err - e0, 0);
    check("wr_fin_latency", last_fin_cyc - rise_cyc, 4);
    check("wr_valid_latency", last_valid_cyc - rise_cyc, 4);
    check("wr_ratio", int'(cfg_ratio), 11);
    check("wr_pllen", int'(cfg_pllen), 1);

    // Read-only frame with lock high: status tail on miso
    lock = 1'b1;
    w = '0; w[0] = 1'b1; w[12:3] = 10'd3;
    v0 = n_valid; f0 = n_fin;
    exp_tail = {1'b1, m_pllen, m_ratio};
    load(w, DW, 0);
    send_frame(0);
    check("rd_valid_cnt", n_valid - v0, 0);
    check("rd_fin_cnt", n_fin - f0, 1);
    check("rd_ratio", int'(cfg_ratio), 11);
    for (int i = 0; i < 12; i++) tail[11-i] = cap[DW-12+i];
    ones = 0;
    for (int i = 0; i < DW - 12; i++) ones += int'(cap[i]);
    check("rd_miso_cnt", cap.size(), DW);
    check("rd_miso_tail", int'(tail), 12'hC0B);
    check("rd_miso_tail_model", int'(tail), int'(exp_tail));
    check("rd_miso_lead_zero", ones, 0);
    lock = 1'b0;

    // Short frame of 300 bits with write set: error only
    w = '0; w[1] = 1'b1; w[2] = 1'b0; w[12:3] = 10'd77;
    v0 = n_valid; f0 = n_fin; e0 = n_err;
    load(w, 300, 0);
    send_frame(0);
    check("short_err_cnt", n_err - e0, 1);
    check("short_fin_cnt", n_fin - f0, 0);
    check("short_valid_cnt", n_valid - v0, 0);
    check("short_ratio", int'(cfg_ratio), 11);
    check("short_pllen", int'(cfg_pllen), 1);

    // Long frame: 8 leading ones then a 512-bit write of ratio=700, pllen=0
    w = '0; w[1] = 1'b1; w[12:3] = 10'd700;
    v0 = n_valid; f0 = n_fin; e0 = n_err;
    load(w, DW, 8);
    send_frame(0);
    check("long_fin_cnt", n_fin - f0, 1);
    check("long_valid_cnt", n_valid - v0, 1);
    check("long_err_cnt", n_err - e0, 0);
    check("long_ratio", int'(cfg_ratio), 700);
    check("long_pllen", int'(cfg_pllen), 0);

    // Reset after 200 bits, then a full write of ratio=9
    w = '0; w[1] = 1'b1; w[2] = 1'b1; w[12:3] = 10'd5;
    v0 = n_valid; f0 = n_fin; e0 = n_err;
    load(w, DW, 0);
    send_frame(200);
    check("abort_pulses", (n_valid - v0) + (n_fin - f0) + (n_err - e0), 0);
    check("abort_ratio_rst", int'(cfg_ratio), 6);
    w = '0; w[1] = 1'b1; w[2] = 1'b1; w[12:3] = 10'd9;
    load(w, DW, 0);
    send_frame(0);
    check("post_rst_valid_cnt", n_valid - v0, 1);
    check("post_rst_err_cnt", n_err - e0, 0);
    check("post_rst_ratio", int'(cfg_ratio), 9);
    check("post_rst_pllen", int'(cfg_pllen), 1);

    repeat (5) @(posedge clk); #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pllmap_spi_rx.md
# pllmap_spi_rx

SPI slave receive/decode stage sitting directly downstream of the SPI master and upstream of the PLL map core inside `pllmap_top`. It oversamples the master's `sclk`/`mosi`/`ss_n` in the system clock domain and deserializes one fixed-length frame per `ss_n` low window. It decodes the command fields into registered PLL control values and shifts a status word back on `miso`. It flags malformed frames.

## Interface
- `DATA_WIDTH`, 512, frame length in bits.
- `RATIO_RST`, 10'd6, reset value of `cfg_ratio`.
- `clk`  in  1  system clock; every flop in the block is on this clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `sclk`  in  1  SPI clock from master, asynchronous to `clk`; idle low (mode 0).
- `mosi`  in  1  serial data from master, MSB first.
- `ss_n`  in  1  active-low frame select.
- `lock`  in  1  PLL lock, sampled into the status word.
- `miso`  out  1  serial status to master.
- `cfg_ratio`  out  10  registered divide ratio.
- `cfg_pllen`  out  1  registered PLL enable.
- `cfg_valid`  out  1  one-cycle pulse when `cfg_*` is updated.
- `rx_finish`  out  1  one-cycle pulse on every good frame end.
- `frame_err`  out  1  one-cycle pulse on a bad frame end.

## Operation
- **Synchronization.** `sclk`, `mosi` and `ss_n` each pass through a 2-flop synchronizer. A third register provides edge detect. Rising and falling `sclk` edges and the `ss_n` fall/rise events are all derived from the synchronized signals.
- **FSM states:** IDLE, SHIFT, DONE.
- **IDLE → SHIFT** on the `ss_n` falling event.
  - Clear the bit counter (width `$clog2(DATA_WIDTH)+1`).
  - Load the shadow status register with `{lock, cfg_pllen, cfg_ratio}` in bits [11:0]; all other bits are 0.
  - Drive `miso` with the shadow MSB.
- **SHIFT**
  - On an `sclk` rising event: `frame <= {frame[DATA_WIDTH-2:0], mosi_sync}` and increment the counter. The counter saturates at `DATA_WIDTH`. Extra bits keep shifting, but the counter does not wrap.
  - On an `sclk` falling event: shift the shadow register left and drive `miso` with its new MSB.
  - On the `ss_n` rising event: go to DONE.
- **DONE** (one cycle), then return to IDLE.
  - If the counter equals `DATA_WIDTH`, the frame is good:
    - Pulse `rx_finish`.
    - If `frame[1]` (write) = 1: `cfg_pllen <= frame[2]`, `cfg_ratio <= frame[12:3]`, and pulse `cfg_valid`.
    - `frame[0]` (read) only selects that status is meaningful. It has no side effect.
    - Write and read both set: the update is performed.
    - Neither bit set: `rx_finish` only.
  - Otherwise the frame is bad: pulse `frame_err`. `cfg_*` is unchanged and `rx_finish` stays low.
- If an `ss_n` falling event arrives during DONE, it is taken on the next IDLE cycle; the block does not miss it because synchronized `ss_n` is still low.
- `ss_n` rising event in IDLE (a glitch): ignored.
- **Reset:** asserting `rst_n` mid-frame immediately aborts the frame. The FSM goes to IDLE with no pulse.

## Timing
- **Reset values:** `miso`=0, `cfg_ratio`=`RATIO_RST`, `cfg_pllen`=0, `cfg_valid`=0, `rx_finish`=0, `frame_err`=0. The frame register, counter and shadow register are all 0.
- **Input latency:** 3 `clk` cycles from a pin edge to the internal event.
- **Frame-end latency:** `cfg_*`, `cfg_valid` and `rx_finish` change exactly 4 `clk` cycles after the `ss_n` pin rise (3 cycles sync/edge detect + DONE). `cfg_valid` and `rx_finish` are high for exactly 1 cycle, in the same cycle.
- **Minimum `sclk` half-period:** 4 `clk` cycles. The master's 50 MHz/5 MHz configuration gives 5 cycles.
- **`miso` timing:** `miso` changes within 4 `clk` cycles of an `sclk` pin fall and is stable at the master's next `sclk` rise.
- **Inter-frame gap:** `ss_n` high for ≥2 `clk` cycles between frames.

## Test plan
- **Reset defaults:** assert `rst_n` low, then release with no traffic → `cfg_ratio`=6, `cfg_pllen`=0, all pulses low, `miso`=0.
- **Write frame:** frame with bit1=1, bit2=1, ratio=11 (all other bits 0) → one `cfg_valid` and one `rx_finish` pulse 4 cycles after `ss_n` rises; `cfg_ratio`=11, `cfg_pllen`=1.
- **Read-only frame:** frame with bit0=1, bit1=0, ratio=3 → `rx_finish` pulses, no `cfg_valid`, `cfg_ratio` stays 11.
  - During that frame with `lock`=1, the last 12 bits captured on `miso` = `{1,1,10'd11}`; all earlier bits are 0.
- **Short frame:** `ss_n` rises after 300 bits with write=1 → `frame_err` pulses once; no `rx_finish`, no `cfg_valid`; `cfg_*` unchanged.
- **Long frame:** 520 bits with write=1, ratio taken from the last 512 bits shifted → treated as good (counter saturated); `cfg_ratio` equals bits [12:3] of the final 512 shifted bits.
- **Reset mid-frame:** pull `rst_n` low after 200 bits, release, then send a full write frame with ratio=9 → no pulse from the aborted frame; the second frame yields `cfg_ratio`=9 with a single `cfg_valid`.
